// File: rtl/hazard_sb.sv
// hazard_sb: register scoreboard for a single-issue pipeline.
// Holds a small saturating count of in-flight writes per architectural
// register and stalls decode/fetch while a source operand is still pending
// or while the destination's counter is already full. Register 0 is
// hardwired and never tracked.
// Optional build macro HAZARD_SB_STAT_EN adds a 32-bit stall-cycle counter
// output (stall_cnt).
module hazard_sb #(
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ds_use_rs,
    input  logic              ds_use_rt,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              ds_write_reg,
    input  logic [REG_AW-1:0] ds_reg_dest,
    input  logic              ds_issue,
    input  logic              ws_write_reg,
    input  logic [REG_AW-1:0] ws_reg_dest,
    input  logic              flush,
    output logic              stallD,
    output logic              stallF,
`ifdef HAZARD_SB_STAT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              sb_err
);

    localparam int unsigned      NREG = 1 << REG_AW;
    localparam logic [CNT_W-1:0] MAX  = '1;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [CNT_W-1:0] pend [NREG];

    logic inc_en;
    logic dec_en;
    logic same_reg;
    logic inc_sat;
    logic dec_sat;
    logic violation;
    logic rs_busy;
    logic rt_busy;
    logic dest_full;

    // Hazard detection from registered counters only, plus update qualifiers
    always_comb begin
        rs_busy   = 1'b0;
        rt_busy   = 1'b0;
        dest_full = 1'b0;
        inc_en    = 1'b0;
        dec_en    = 1'b0;
        same_reg  = 1'b0;
        inc_sat   = 1'b0;
        dec_sat   = 1'b0;
        violation = 1'b0;

        rs_busy   = ds_use_rs && (rs_addr != '0) && (pend[rs_addr] != '0);
        rt_busy   = ds_use_rt && (rt_addr != '0) && (pend[rt_addr] != '0);
        dest_full = ds_write_reg && (ds_reg_dest != '0) && (pend[ds_reg_dest] == MAX);

        stallD = rs_busy || rt_busy || dest_full;
        stallF = stallD;

        inc_en   = ds_issue && ds_write_reg && (ds_reg_dest != '0);
        dec_en   = ws_write_reg && (ws_reg_dest != '0);
        // Issue and retire of the same register cancel out, so neither can
        // saturate in that case.
        same_reg = inc_en && dec_en && (ds_reg_dest == ws_reg_dest);
        inc_sat  = inc_en && !same_reg && (pend[ds_reg_dest] == MAX);
        dec_sat  = dec_en && !same_reg && (pend[ws_reg_dest] == '0);

        violation = ds_issue && stallD;
    end

    // Pending counters: reset/flush clear everything, otherwise saturating inc/dec
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                pend[i] <= '0;
            end
        end else begin
            if (inc_en && !same_reg && !inc_sat) begin
                pend[ds_reg_dest] <= pend[ds_reg_dest] + ONE;
            end
            if (dec_en && !same_reg && !dec_sat) begin
                pend[ws_reg_dest] <= pend[ws_reg_dest] - ONE;
            end
            pend[0] <= '0;
        end
    end

    // Sticky protocol-violation flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err <= 1'b0;
        end else if (violation || (!flush && (inc_sat || dec_sat))) begin
            sb_err <= 1'b1;
        end
    end

`ifdef HAZARD_SB_STAT_EN
    // Free-running count of stalled decode cycles; wraps naturally, flush-immune
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stallD) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/hazard_sb.md
HAZARD_SB -- requirements
Module: hazard_sb

Interface
- REQ-001 SHALL have parameter REG_AW, default 5, meaning register address width; tracks 2^REG_AW registers.
- REQ-002 SHALL have parameter CNT_W, default 2, meaning pending-counter width; per-register limit MAX = 2^CNT_W-1 in-flight writes.
- REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
- REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
- REQ-005 SHALL have ports ds_use_rs/ds_use_rt  in  1 each  decode reads rs/rt.
- REQ-006 SHALL have ports rs_addr/rt_addr  in  REG_AW each  decode source registers.
- REQ-007 SHALL have port ds_write_reg  in  1  decode instruction writes a register.
- REQ-008 SHALL have port ds_reg_dest  in  REG_AW  decode destination register.
- REQ-009 SHALL have port ds_issue  in  1  decode-to-execute transfer fires this cycle.
- REQ-010 SHALL have port ws_write_reg  in  1  writeback commits a register write this cycle.
- REQ-011 SHALL have port ws_reg_dest  in  REG_AW  writeback destination.
- REQ-012 SHALL have port flush  in  1  discard all in-flight writes.
- REQ-013 SHALL have ports stallD/stallF  out  1 each  hold decode/fetch.
- REQ-014 SHALL have port sb_err  out  1  sticky protocol-violation flag.

Function
- REQ-015 SHALL keep one CNT_W-bit pending counter per register; register 0 never tracked, always reads 0.
- REQ-016 SHALL increment pend[ds_reg_dest] at the edge when ds_issue && ds_write_reg && ds_reg_dest!=0.
- REQ-017 SHALL decrement pend[ws_reg_dest] at the edge when ws_write_reg && ws_reg_dest!=0.
- REQ-018 SHALL leave a counter unchanged when increment and decrement target the same register in the same cycle.
- REQ-019 SHALL saturate: increment at MAX keeps MAX, decrement at 0 keeps 0; either case sets sb_err on that edge.
- REQ-020 SHALL assert stallD combinationally when (ds_use_rs && rs_addr!=0 && pend[rs_addr]!=0) or (ds_use_rt && rt_addr!=0 && pend[rt_addr]!=0).
- REQ-021 SHALL also assert stallD when ds_write_reg && ds_reg_dest!=0 && pend[ds_reg_dest]==MAX.
- REQ-022 SHALL drive stallF equal to stallD.
- REQ-023 SHALL evaluate stall from registered counters only; a same-cycle writeback does not release the stall until the next cycle.
- REQ-024 SHALL treat ds_issue while stallD=1 as a violation: counter updated per REQ-016, sb_err set.
- REQ-025 SHALL clear all counters at the edge when flush=1, overriding same-cycle issue and retire; sb_err unaffected.
- REQ-026 SHALL keep sb_err set until reset.

Reset
- REQ-027 SHALL on reset=1 at an edge clear all counters and sb_err, overriding flush, issue and retire.
- REQ-028 SHALL, with counters clear, drive stallD=stallF=0 from the first cycle after reset.

Configuration
- REQ-029 SHALL, with macro HAZARD_SB_STAT_EN defined, add output stall_cnt (32 bits) that increments each cycle stallD=1, wraps at 2^32-1 to 0, is cleared by reset and not by flush.
- REQ-030 SHALL, without HAZARD_SB_STAT_EN, omit stall_cnt and its logic entirely; all other behaviour identical.

Verification
- REQ-031 SHALL cover: issue dest=5, then rs_addr=5 ds_use_rs=1 -> stallD=1 each cycle until one cycle after ws_write_reg dest=5, then 0.
- REQ-032 SHALL cover: issue dest=0, then rs_addr=0 -> stallD=0, no counter change, sb_err=0.
- REQ-033 SHALL cover, with CNT_W=2: three issues dest=7 -> pend=3, ds_write_reg dest=7 -> stallD=1; fourth forced issue -> pend stays 3, sb_err=1.
- REQ-034 SHALL cover: pend[9]=1, same cycle issue dest=9 and retire dest=9 -> pend[9]=1 next cycle.
- REQ-035 SHALL cover: pend[3]=2, pend[4]=1, flush with same-cycle issue dest=3 -> all counters 0, stallD=0 next cycle.
- REQ-036 SHALL cover, with HAZARD_SB_STAT_EN: 4 stall cycles -> stall_cnt=4; flush -> 4 retained; reset -> 0.
